// File: rtl/surf_cout_pkg.sv
// surf_cout_pkg
//   Shared types and constants for the SURF COUT training-capture block:
//   the per-lane lock state encoding and the default training word.
package surf_cout_pkg;

   // Training word seen on every COUT lane while the SURF is in training mode.
   localparam logic [31:0] TRAIN_PATTERN_DEF = 32'hA55A6996;

   typedef enum logic [1:0] {
      LS_UNLOCKED = 2'd0,
      LS_CHECKING = 2'd1,
      LS_LOCKED   = 2'd2
   } lock_state_e;

endpackage

// File: rtl/surf_cout_lane_check.sv
// surf_cout_lane_check
//   One COUT lane: assembles frames from NIB-bit beats, compares each
//   complete frame with the training word, runs the lock FSM and keeps a
//   saturating mismatch counter.
// Ports:
//   sysclk_i, rst_i  clock, synchronous active-high reset
//   beat_i           this lane's NIB-bit beat for the current cycle
//   done_i           current beat is the last of a valid (aligned) frame
//   enable_i         pattern check enable for this lane
//   clr_err_i        zero the error counter
//   word_o           full frame word, valid while done_i is high
//   biterr_o         one-cycle mismatch pulse, one cycle after done_i
//   locked_o         high while in LOCKED
//   errcnt_o         saturating mismatch count
module surf_cout_lane_check
   import surf_cout_pkg::*;
#(
   parameter int                      NIB           = 4,
   parameter int                      NBEATS        = 8,
   parameter logic [NIB*NBEATS-1:0]   TRAIN_PATTERN = TRAIN_PATTERN_DEF,
   parameter int                      LOCK_CNT      = 4,
   parameter int                      ERRCNT_W      = 16
) (
   input  logic                       sysclk_i,
   input  logic                       rst_i,
   input  logic [NIB-1:0]             beat_i,
   input  logic                       done_i,
   input  logic                       enable_i,
   input  logic                       clr_err_i,
   output logic [NIB*NBEATS-1:0]      word_o,
   output logic                       biterr_o,
   output logic                       locked_o,
   output logic [ERRCNT_W-1:0]        errcnt_o
);

   localparam int FW = NIB * NBEATS;
   localparam int GW = $clog2(LOCK_CNT + 1);

   logic [FW-1:0]       sr_q;
   logic                biterr_q;
   logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;
   logic [GW-1:0]       good_q, good_d;
   lock_state_e         state_q, state_d;
   logic                bad, good;

   // The current beat completes the word, so the compare sees the frame in
   // the completion cycle and the result registers one cycle later.
   assign word_o = {sr_q[FW-NIB-1:0], beat_i};
   assign bad    = done_i & enable_i & (word_o != TRAIN_PATTERN);
   assign good   = done_i & enable_i & (word_o == TRAIN_PATTERN);

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      if (!enable_i) begin
         state_d = LS_UNLOCKED;
         good_d  = '0;
      end else begin
         unique case (state_q)
            LS_UNLOCKED: begin
               state_d = LS_CHECKING;
               good_d  = '0;
            end
            LS_CHECKING: begin
               if (bad) begin
                  good_d = '0;
               end else if (good) begin
                  if (good_q == GW'(LOCK_CNT - 1)) begin
                     state_d = LS_LOCKED;
                     good_d  = '0;
                  end else begin
                     good_d = good_q + 1'b1;
                  end
               end
            end
            LS_LOCKED: begin
               if (bad) state_d = LS_UNLOCKED;
            end
            default: state_d = LS_UNLOCKED;
         endcase
      end
   end

   // Clear takes priority over an increment in the same cycle.
   always_comb begin
      errcnt_d = errcnt_q;
      if (clr_err_i)                  errcnt_d = '0;
      else if (bad && errcnt_q != '1) errcnt_d = errcnt_q + 1'b1;
   end

   always_ff @(posedge sysclk_i) begin
      if (rst_i) begin
         sr_q     <= '0;
         biterr_q <= 1'b0;
         errcnt_q <= '0;
         good_q   <= '0;
         state_q  <= LS_UNLOCKED;
      end else begin
         sr_q     <= word_o;
         biterr_q <= bad;
         errcnt_q <= errcnt_d;
         good_q   <= good_d;
         state_q  <= state_d;
      end
   end

   assign biterr_o = biterr_q;
   assign locked_o = (state_q == LS_LOCKED);
   assign errcnt_o = errcnt_q;

endmodule

// File: rtl/surf_cout_train_capture.sv
// surf_cout_train_capture
//   Frames the deserialized SURF COUT lanes with a shared beat counter,
//   checks every lane against the training word and provides a one-shot
//   capture of one lane's frame.
// Ports:
//   sysclk_i, rst_i  clock, synchronous active-high reset
//   sync_i           frame alignment strobe (next cycle is beat 0)
//   cout_i           NCH lanes of NIB-bit beats, lane c at [c*NIB +: NIB]
//   enable_i         per-lane check enable
//   capture_i        arm a one-shot capture
//   sel_i            lane for capture and error-count readout
//   clr_err_i        clear all error counters
//   data_o, valid_o  captured frame and its one-cycle strobe
//   locked_o         per-lane lock status
//   biterr_o         per-lane mismatch pulse
//   errcnt_o         error count of lane sel_i (one-cycle latency)
module surf_cout_train_capture
   import surf_cout_pkg::*;
#(
   parameter int                      NCH           = 7,
   parameter int                      NIB           = 4,
   parameter int                      NBEATS        = 8,
   parameter logic [NIB*NBEATS-1:0]   TRAIN_PATTERN = TRAIN_PATTERN_DEF,
   parameter int                      LOCK_CNT      = 4,
   parameter int                      ERRCNT_W      = 16
) (
   input  logic                       sysclk_i,
   input  logic                       rst_i,
   input  logic                       sync_i,
   input  logic [NCH*NIB-1:0]         cout_i,
   input  logic [NCH-1:0]             enable_i,
   input  logic                       capture_i,
   input  logic [$clog2(NCH)-1:0]     sel_i,
   input  logic                       clr_err_i,
   output logic [NIB*NBEATS-1:0]      data_o,
   output logic                       valid_o,
   output logic [NCH-1:0]             locked_o,
   output logic [NCH-1:0]             biterr_o,
   output logic [ERRCNT_W-1:0]        errcnt_o
);

   localparam int FW = NIB * NBEATS;
   localparam int BW = $clog2(NBEATS);
   localparam int SW = $clog2(NCH);

   logic [BW-1:0]       beat_q, beat_d;
   logic                synced_q, synced_d;
   logic                armed_q, armed_d;
   logic [FW-1:0]       data_q, data_d;
   logic                valid_q, valid_d;
   logic [ERRCNT_W-1:0] errcnt_q;
   logic                done;

   logic [NCH-1:0][FW-1:0]       lane_word;
   logic [NCH-1:0][ERRCNT_W-1:0] lane_cnt;
   logic [FW-1:0]                sel_word;
   logic [ERRCNT_W-1:0]          sel_cnt;

   // Frames only count once a sync has aligned the counter. A sync mid-frame
   // restarts the count, so the interrupted frame never reaches its last beat.
   assign done = synced_q && (beat_q == BW'(NBEATS - 1));

   for (genvar g = 0; g < NCH; g++) begin : g_lane
      surf_cout_lane_check #(
         .NIB           (NIB),
         .NBEATS        (NBEATS),
         .TRAIN_PATTERN (TRAIN_PATTERN),
         .LOCK_CNT      (LOCK_CNT),
         .ERRCNT_W      (ERRCNT_W)
      ) u_lane (
         .sysclk_i  (sysclk_i),
         .rst_i     (rst_i),
         .beat_i    (cout_i[g*NIB +: NIB]),
         .done_i    (done),
         .enable_i  (enable_i[g]),
         .clr_err_i (clr_err_i),
         .word_o    (lane_word[g]),
         .biterr_o  (biterr_o[g]),
         .locked_o  (locked_o[g]),
         .errcnt_o  (lane_cnt[g])
      );
   end

   // Out-of-range selects read as zero.
   always_comb begin
      sel_word = '0;
      sel_cnt  = '0;
      for (int i = 0; i < NCH; i++) begin
         if (sel_i == SW'(i)) begin
            sel_word = lane_word[i];
            sel_cnt  = lane_cnt[i];
         end
      end
   end

   always_comb begin
      beat_d   = (sync_i || beat_q == BW'(NBEATS - 1)) ? '0 : beat_q + 1'b1;
      synced_d = synced_q | sync_i;
      armed_d  = armed_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      // An armed capture takes the frame completing now; a capture request
      // arriving on that same cycle (or any time while armed) is dropped,
      // while one arriving unarmed on a completion cycle waits for the next.
      if (armed_q && done) begin
         data_d  = sel_word;
         valid_d = 1'b1;
         armed_d = 1'b0;
      end else if (!armed_q && capture_i) begin
         armed_d = 1'b1;
      end
   end

   always_ff @(posedge sysclk_i) begin
      if (rst_i) begin
         beat_q   <= '0;
         synced_q <= 1'b0;
         armed_q  <= 1'b0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         errcnt_q <= '0;
      end else begin
         beat_q   <= beat_d;
         synced_q <= synced_d;
         armed_q  <= armed_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         errcnt_q <= sel_cnt;
      end
   end

   assign data_o   = data_q;
   assign valid_o  = valid_q;
   assign errcnt_o = errcnt_q;

endmodule

// File: doc/surf_cout_train_capture.md
SURF_COUT_TRAIN_CAPTURE -- requirements
Module: surf_cout_train_capture

Interface
REQ-001 Parameter NCH, default 7: number of SURF COUT channels.
REQ-002 Parameter NIB, default 4: bits per channel per sysclk beat.
REQ-003 Parameter NBEATS, default 8: beats per frame; frame width FW = NIB*NBEATS.
REQ-004 Parameter TRAIN_PATTERN, FW bits, default 32'hA55A6996: expected training word.
REQ-005 Parameter LOCK_CNT, default 4: consecutive good frames required to lock.
REQ-006 Parameter ERRCNT_W, default 16: error counter width.
REQ-007 sysclk_i  in  1  sole clock.
REQ-008 rst_i  in  1  reset, synchronous, active-high.
REQ-009 sync_i  in  1  frame alignment strobe.
REQ-010 cout_i  in  NCH*NIB  deserialized COUT beats; channel c occupies [c*NIB +: NIB].
REQ-011 enable_i  in  NCH  per-channel pattern check enable.
REQ-012 capture_i  in  1  single-cycle pulse arming a one-shot frame capture.
REQ-013 sel_i  in  clog2(NCH)  channel selected for capture and error counter readout.
REQ-014 clr_err_i  in  1  clears all error counters.
REQ-015 data_o  out  FW  captured frame of selected channel.
REQ-016 valid_o  out  1  single-cycle pulse, data_o updated.
REQ-017 locked_o  out  NCH  per-channel lock status.
REQ-018 biterr_o  out  NCH  per-channel single-cycle mismatch pulse.
REQ-019 errcnt_o  out  ERRCNT_W  error count of channel sel_i.

Function
REQ-020 One shared beat counter shall run 0..NBEATS-1 and wrap; sync_i high shall force the count to 0 for the next cycle.
REQ-021 Beat 0 shall land in frame bits [FW-1 -: NIB], MSB first; beat NBEATS-1 in [NIB-1:0].
REQ-022 A frame is complete on the cycle the counter reads NBEATS-1; its word shall be registered the following cycle (frame latency 1).
REQ-023 A frame interrupted by sync_i, or begun before the first sync_i after reset, shall be discarded: no compare, no capture.
REQ-024 For each complete frame with enable_i[c]=1, mismatch against TRAIN_PATTERN shall pulse biterr_o[c] for one cycle, one cycle after frame completion.
REQ-025 Each mismatch shall increment channel c's counter, saturating at 2^ERRCNT_W-1; clr_err_i shall zero all counters and wins over a simultaneous increment.
REQ-026 Per-channel lock FSM: UNLOCKED -> CHECKING on enable; CHECKING -> LOCKED after LOCK_CNT consecutive good frames; CHECKING -> CHECKING with good count reset to 0 on mismatch; LOCKED -> UNLOCKED on any mismatch; any state -> UNLOCKED when enable_i[c]=0.
REQ-027 locked_o[c] shall be high only in LOCKED, updating in the same cycle biterr_o would pulse.
REQ-028 capture_i shall arm; the next complete frame of channel sel_i (enable not required) shall load data_o and pulse valid_o once; then disarm.
REQ-029 capture_i while armed shall be ignored; capture_i coincident with frame completion shall capture the following frame.
REQ-030 sel_i shall be sampled at frame completion for capture; errcnt_o shall follow sel_i with one-cycle latency.

Reset
REQ-031 rst_i shall zero counter, shift registers, data_o, valid_o, biterr_o, all error counters, clear arm and first-sync flags, and place all FSMs in UNLOCKED (locked_o=0).
REQ-032 rst_i mid-frame or mid-capture shall abandon that frame with no biterr_o or valid_o pulse.

Structure
REQ-033 Lock-state enum and default TRAIN_PATTERN shall live in package surf_cout_pkg.
REQ-034 Per-channel shift register, compare, lock FSM and error counter shall be sub-module surf_cout_lane_check, instantiated NCH times by generate.

Verification
REQ-035 Sync, then channel 0 fed A,5,5,A,6,9,9,6 repeatedly, enable_i[0]=1 -> no biterr_o, locked_o[0]=1 after 4th frame.
REQ-036 Locked channel 2 gets one frame 0xA55A6997 -> biterr_o[2] one pulse, locked_o[2]=0, errcnt (sel_i=2) =1, relock after 4 good frames.
REQ-037 capture_i with sel_i=3, channel 3 fed 0x12345678 -> exactly one valid_o, data_o=0x12345678, no further valid_o.
REQ-038 sync_i at beat 4 -> partial frame discarded, no biterr_o; next 8 beats compared normally.
REQ-039 ERRCNT_W=4, 20 bad frames -> errcnt_o holds 15; clr_err_i coincident with 21st error -> 0.
REQ-040 rst_i asserted at beat 5 with capture armed -> all outputs 0, no valid_o until a new capture_i after the next sync_i.
